ace_to_axi_rd_adapter: RTL and testbench
========================================

Name: ace_to_axi_rd_adapter

Overview:
Slave-side endpoint for the read half of an ACE bus, between an ACE master port and a plain AXI4 memory port. It does four things:
- Forwards data-carrying reads (ReadNoSnoop/ReadOnce/ReadShared/ReadClean/ReadNotSharedDirty/ReadUnique) to AXI.
- Answers barriers, cache-maintenance and DVM requests locally.
- Widens the AXI 2-bit RRESP to the ACE 4-bit RRESP.
- Bounds outstanding downstream reads.

Parameters:
AddrWidth, 64, address width
DataWidth, 64, data width
IdWidth, 4, ID width (same on both sides)
UserWidth, 1, user width
MaxTxns, 8, max outstanding forwarded reads (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
slv_ar_id/addr/len/size/burst/lock/cache/prot/qos/region/user  in  per axi_pkg/params  ACE AR payload
slv_ar_snoop  in  4  ace_pkg::arsnoop_t
slv_ar_bar  in  2  ace_pkg::bar_t
slv_ar_domain  in  2  ace_pkg::domain_t
slv_ar_valid  in  1; slv_ar_ready  out  1
slv_r_id  out  IdWidth; slv_r_data  out  DataWidth; slv_r_resp  out  4 (ace_pkg::rresp_t); slv_r_last  out  1; slv_r_user  out  UserWidth
slv_r_valid  out  1; slv_r_ready  in  1
mst_ar_*  out  AXI AR payload (no snoop/bar/domain); mst_ar_valid  out  1; mst_ar_ready  in  1
mst_r_id/data/resp(2)/last/user  in; mst_r_valid  in  1; mst_r_ready  out  1

Behaviour:
- Classification of the AR beat:
  - LOCAL_OK when slv_ar_bar[0]=1, or arsnoop is one of CleanShared 1000, CleanInvalid 1001, CleanUnique 1011, MakeUnique 1100, MakeInvalid 1101, DVM Complete 1110, DVM Message 1111.
  - FWD when arsnoop is one of 0000, 0001, 0010, 0011, 0111.
  - LOCAL_ERR for all other encodings (0100, 0101, 0110, 1010).
  - Barrier takes precedence over arsnoop.
- Outstanding counter cnt, width $clog2(MaxTxns+1):
  - +1 on mst AR handshake; −1 on mst R handshake with last=1.
  - Both in the same cycle: unchanged.
  - Never exceeds MaxTxns; never underflows (assert).
- FSM states IDLE, DRAIN, RESP. Reset state IDLE, cnt=0.
- IDLE, FWD:
  - mst_ar_valid = slv_ar_valid && cnt<MaxTxns.
  - slv_ar_ready = mst_ar_ready && cnt<MaxTxns.
  - Payload passes combinationally (0-cycle latency).
  - At cnt==MaxTxns: both low until a last beat retires.
- IDLE, LOCAL_*:
  - slv_ar_ready=1 and mst_ar_valid=0.
  - Capture id, user, and err flag.
  - Next state: RESP if cnt==0 (counting this cycle's decrement), else DRAIN.
- DRAIN:
  - slv_ar_ready=0; mst R traffic continues.
  - Go to RESP the cycle after cnt reaches 0.
- RESP:
  - slv_r_valid=1, slv_r_id=captured id, slv_r_user=captured user, slv_r_last=1, slv_r_data=0.
  - slv_r_resp = {IsShared=0, PassDirty=0, err ? 2'b10 : 2'b00}.
  - mst_r_ready=0 (nothing is in flight anyway).
  - On slv_r_ready: go to IDLE.
  - R stays stable while valid && !ready.
- R path outside RESP:
  - slv_r_* = mst_r_*, with slv_r_resp = {2'b00, mst_r_resp}.
  - mst_r_ready = slv_r_ready.
- Local-response latency: accept in cycle N, slv_r_valid in cycle N+1 at the earliest.
- Ordering: a local response never overtakes an earlier forwarded read.
- Reset:
  - While rst_i=1: slv_ar_ready, slv_r_valid, mst_ar_valid and mst_r_ready are all 0.
  - Reset asserted mid-operation returns to IDLE with cnt=0 and drops any captured local response.
  - Draining downstream in-flight reads after a reset is the system's responsibility.
- AR payload stability while valid && !ready is inherited by the mst side.

Decomposition:
- Add to ace_pkg:
  - arsnoop encoding localparams (ReadNoSnoop … DVMMessage).
  - function ar_is_data_read(arsnoop_t).
  - function ar_is_maint(arsnoop_t).
  - function rresp_from_axi(axi_pkg::resp_t, pass_dirty, is_shared).
- FSM state enum stays local.
- No sub-module is natural; the counter is inline.

Test Plan:
1. ReadShared (arsnoop=0001, id=3, len=3) with cnt=0 and immediate mst_ar_ready → mst_ar_valid in the same cycle; the 4 mst R beats with resp=00 appear on slv R with r_resp=4'b0000, last on beat 4; cnt goes 0→1→0.
2. MaxTxns=2: three back-to-back ReadOnce → the third AR is stalled with slv_ar_ready=0 until the first last-beat retires, then accepted the next cycle.
3. Barrier (bar=01, id=5) while 2 reads are outstanding → AR accepted, state DRAIN; after both last beats, one R beat with id=5, resp=0000, last=1, data=0.
4. CleanInvalid (1001, id=7) at cnt=0 → slv_r_valid the next cycle; slv_r_ready held low 3 cycles → response held stable; then IDLE.
5. Reserved arsnoop 0101 (id=2) → no mst AR; single R beat with resp=4'b0010, last=1.
6. rst_i asserted in DRAIN with cnt=1 → next cycle IDLE, cnt=0, all valid/ready outputs 0 during reset; a fresh ReadNoSnoop then forwards normally.

Source files
------------

// File: rtl/ace_to_axi_rd_adapter_pkg.sv
// Shared types and helpers for the ACE-to-AXI read adapter.
// Holds the ARSNOOP encodings, response types and classification functions.
package ace_to_axi_rd_adapter_pkg;

    typedef logic [3:0] arsnoop_t;
    typedef logic [1:0] bar_t;
    typedef logic [1:0] domain_t;
    typedef logic [3:0] rresp_t;
    typedef logic [1:0] resp_t;

    localparam arsnoop_t ReadNoSnoop        = 4'b0000;
    localparam arsnoop_t ReadOnce           = 4'b0000;
    localparam arsnoop_t ReadShared         = 4'b0001;
    localparam arsnoop_t ReadClean          = 4'b0010;
    localparam arsnoop_t ReadNotSharedDirty = 4'b0011;
    localparam arsnoop_t ReadUnique         = 4'b0111;
    localparam arsnoop_t CleanShared        = 4'b1000;
    localparam arsnoop_t CleanInvalid       = 4'b1001;
    localparam arsnoop_t CleanUnique        = 4'b1011;
    localparam arsnoop_t MakeUnique         = 4'b1100;
    localparam arsnoop_t MakeInvalid        = 4'b1101;
    localparam arsnoop_t DVMComplete        = 4'b1110;
    localparam arsnoop_t DVMMessage         = 4'b1111;

    localparam resp_t RespOkay   = 2'b00;
    localparam resp_t RespSlvErr = 2'b10;

    function automatic logic ar_is_data_read(arsnoop_t s);
        return (s == ReadNoSnoop) || (s == ReadShared) ||
               (s == ReadClean) || (s == ReadNotSharedDirty) ||
               (s == ReadUnique);
    endfunction

    function automatic logic ar_is_maint(arsnoop_t s);
        return (s == CleanShared) || (s == CleanInvalid) ||
               (s == CleanUnique) || (s == MakeUnique) ||
               (s == MakeInvalid) || (s == DVMComplete) ||
               (s == DVMMessage);
    endfunction

    // ACE RRESP = {IsShared, PassDirty, AXI RRESP}
    function automatic rresp_t rresp_from_axi(resp_t r, logic pass_dirty,
                                              logic is_shared);
        return {is_shared, pass_dirty, r};
    endfunction

endpackage

// File: rtl/ace_to_axi_rd_adapter.sv
// ACE read-channel slave endpoint in front of a plain AXI4 read port.
// Ports: clk_i/rst_i; slv_ar_*/slv_r_* (ACE side); mst_ar_*/mst_r_* (AXI side).
// Data reads are forwarded with a bounded outstanding count; barriers,
// maintenance and DVM requests get a single local R beat once drained.
module ace_to_axi_rd_adapter
    import ace_to_axi_rd_adapter_pkg::*;
#(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int IdWidth   = 4,
    parameter int UserWidth = 1,
    parameter int MaxTxns   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IdWidth-1:0]   slv_ar_id,
    input  logic [AddrWidth-1:0] slv_ar_addr,
    input  logic [7:0]           slv_ar_len,
    input  logic [2:0]           slv_ar_size,
    input  logic [1:0]           slv_ar_burst,
    input  logic                 slv_ar_lock,
    input  logic [3:0]           slv_ar_cache,
    input  logic [2:0]           slv_ar_prot,
    input  logic [3:0]           slv_ar_qos,
    input  logic [3:0]           slv_ar_region,
    input  logic [UserWidth-1:0] slv_ar_user,
    input  arsnoop_t             slv_ar_snoop,
    input  bar_t                 slv_ar_bar,
    input  domain_t              slv_ar_domain,
    input  logic                 slv_ar_valid,
    output logic                 slv_ar_ready,
    output logic [IdWidth-1:0]   slv_r_id,
    output logic [DataWidth-1:0] slv_r_data,
    output rresp_t               slv_r_resp,
    output logic                 slv_r_last,
    output logic [UserWidth-1:0] slv_r_user,
    output logic                 slv_r_valid,
    input  logic                 slv_r_ready,
    output logic [IdWidth-1:0]   mst_ar_id,
    output logic [AddrWidth-1:0] mst_ar_addr,
    output logic [7:0]           mst_ar_len,
    output logic [2:0]           mst_ar_size,
    output logic [1:0]           mst_ar_burst,
    output logic                 mst_ar_lock,
    output logic [3:0]           mst_ar_cache,
    output logic [2:0]           mst_ar_prot,
    output logic [3:0]           mst_ar_qos,
    output logic [3:0]           mst_ar_region,
    output logic [UserWidth-1:0] mst_ar_user,
    output logic                 mst_ar_valid,
    input  logic                 mst_ar_ready,
    input  logic [IdWidth-1:0]   mst_r_id,
    input  logic [DataWidth-1:0] mst_r_data,
    input  resp_t                mst_r_resp,
    input  logic                 mst_r_last,
    input  logic [UserWidth-1:0] mst_r_user,
    input  logic                 mst_r_valid,
    output logic                 mst_r_ready
);

    localparam int CntW = $clog2(MaxTxns + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxTxns);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic [1:0] {IDLE, DRAIN, RESP} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [IdWidth-1:0]     id_q, id_d;
    logic [UserWidth-1:0]   user_q, user_d;
    logic                   err_q, err_d;
    logic                   is_fwd, is_err, can_issue;
    logic                   inc, dec, in_resp, drained;
    logic                   unused_ok;

    // Domain is not needed by a memory endpoint; bar[1] only matters
    // when bar[0] marks the beat as a barrier.
    assign unused_ok = ^{slv_ar_domain, slv_ar_bar[1]};

    // Barrier wins over whatever ARSNOOP carries.
    assign is_fwd = !slv_ar_bar[0] && ar_is_data_read(slv_ar_snoop);
    assign is_err = !slv_ar_bar[0] && !ar_is_data_read(slv_ar_snoop)
                    && !ar_is_maint(slv_ar_snoop);
    assign can_issue = cnt_q < CntMax;
    assign in_resp = state_q == RESP;

    assign mst_ar_id     = slv_ar_id;
    assign mst_ar_addr   = slv_ar_addr;
    assign mst_ar_len    = slv_ar_len;
    assign mst_ar_size   = slv_ar_size;
    assign mst_ar_burst  = slv_ar_burst;
    assign mst_ar_lock   = slv_ar_lock;
    assign mst_ar_cache  = slv_ar_cache;
    assign mst_ar_prot   = slv_ar_prot;
    assign mst_ar_qos    = slv_ar_qos;
    assign mst_ar_region = slv_ar_region;
    assign mst_ar_user   = slv_ar_user;

    assign slv_r_valid = !rst_i && (in_resp || mst_r_valid);
    assign slv_r_id    = in_resp ? id_q : mst_r_id;
    assign slv_r_data  = in_resp ? '0 : mst_r_data;
    assign slv_r_last  = in_resp || mst_r_last;
    assign slv_r_user  = in_resp ? user_q : mst_r_user;
    assign slv_r_resp  = in_resp
        ? rresp_from_axi(err_q ? RespSlvErr : RespOkay, 1'b0, 1'b0)
        : rresp_from_axi(mst_r_resp, 1'b0, 1'b0);
    assign mst_r_ready = !rst_i && !in_resp && slv_r_ready;

    assign inc = mst_ar_valid && mst_ar_ready;
    assign dec = mst_r_valid && mst_r_ready && mst_r_last;

    // Drained when nothing is left after this cycle's retirement.
    assign drained = (cnt_q == '0) || (cnt_q == CntOne && dec);

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec) cnt_d = cnt_q + CntOne;
        else if (dec && !inc) cnt_d = cnt_q - CntOne;
    end

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        user_d       = user_q;
        err_d        = err_q;
        slv_ar_ready = 1'b0;
        mst_ar_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (is_fwd) begin
                    mst_ar_valid = slv_ar_valid && can_issue;
                    slv_ar_ready = mst_ar_ready && can_issue;
                end else begin
                    slv_ar_ready = 1'b1;
                    if (slv_ar_valid) begin
                        id_d    = slv_ar_id;
                        user_d  = slv_ar_user;
                        err_d   = is_err;
                        state_d = drained ? RESP : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == '0) state_d = RESP;
            end
            RESP: begin
                if (slv_r_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst_i) begin
            slv_ar_ready = 1'b0;
            mst_ar_valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
            user_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            user_q  <= user_d;
            err_q   <= err_d;
            assert (!(dec && !inc && cnt_q == '0));
            assert (!(inc && !dec && cnt_q == CntMax));
        end
    end

endmodule

// File: tb/tb_ace_to_axi_rd_adapter.sv
// Scoreboard bench for ace_to_axi_rd_adapter with a small in-order AXI memory.
// Memory beat data = address + beat index, AXI resp = address[1:0].
module tb_ace_to_axi_rd_adapter;
    import ace_to_axi_rd_adapter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [3:0]  slv_ar_id;
    logic [63:0] slv_ar_addr;
    logic [7:0]  slv_ar_len;
    logic [2:0]  slv_ar_size;
    logic [1:0]  slv_ar_burst;
    logic        slv_ar_lock;
    logic [3:0]  slv_ar_cache;
    logic [2:0]  slv_ar_prot;
    logic [3:0]  slv_ar_qos;
    logic [3:0]  slv_ar_region;
    logic [0:0]  slv_ar_user;
    logic [3:0]  slv_ar_snoop;
    logic [1:0]  slv_ar_bar;
    logic [1:0]  slv_ar_domain;
    logic        slv_ar_valid;
    logic        slv_ar_ready;
    logic [3:0]  slv_r_id;
    logic [63:0] slv_r_data;
    logic [3:0]  slv_r_resp;
    logic        slv_r_last;
    logic [0:0]  slv_r_user;
    logic        slv_r_valid;
    logic        slv_r_ready;
    logic [3:0]  mst_ar_id;
    logic [63:0] mst_ar_addr;
    logic [7:0]  mst_ar_len;
    logic [2:0]  mst_ar_size;
    logic [1:0]  mst_ar_burst;
    logic        mst_ar_lock;
    logic [3:0]  mst_ar_cache;
    logic [2:0]  mst_ar_prot;
    logic [3:0]  mst_ar_qos;
    logic [3:0]  mst_ar_region;
    logic [0:0]  mst_ar_user;
    logic        mst_ar_valid;
    logic        mst_ar_ready;
    logic [3:0]  mst_r_id;
    logic [63:0] mst_r_data;
    logic [1:0]  mst_r_resp;
    logic        mst_r_last;
    logic [0:0]  mst_r_user;
    logic        mst_r_valid;
    logic        mst_r_ready;

    ace_to_axi_rd_adapter #(
        .AddrWidth(64), .DataWidth(64), .IdWidth(4),
        .UserWidth(1), .MaxTxns(2)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .slv_ar_id(slv_ar_id), .slv_ar_addr(slv_ar_addr),
        .slv_ar_len(slv_ar_len), .slv_ar_size(slv_ar_size),
        .slv_ar_burst(slv_ar_burst), .slv_ar_lock(slv_ar_lock),
        .slv_ar_cache(slv_ar_cache), .slv_ar_prot(slv_ar_prot),
        .slv_ar_qos(slv_ar_qos), .slv_ar_region(slv_ar_region),
        .slv_ar_user(slv_ar_user), .slv_ar_snoop(slv_ar_snoop),
        .slv_ar_bar(slv_ar_bar), .slv_ar_domain(slv_ar_domain),
        .slv_ar_valid(slv_ar_valid), .slv_ar_ready(slv_ar_ready),
        .slv_r_id(slv_r_id), .slv_r_data(slv_r_data),
        .slv_r_resp(slv_r_resp), .slv_r_last(slv_r_last),
        .slv_r_user(slv_r_user), .slv_r_valid(slv_r_valid),
        .slv_r_ready(slv_r_ready),
        .mst_ar_id(mst_ar_id), .mst_ar_addr(mst_ar_addr),
        .mst_ar_len(mst_ar_len), .mst_ar_size(mst_ar_size),
        .mst_ar_burst(mst_ar_burst), .mst_ar_lock(mst_ar_lock),
        .mst_ar_cache(mst_ar_cache), .mst_ar_prot(mst_ar_prot),
        .mst_ar_qos(mst_ar_qos), .mst_ar_region(mst_ar_region),
        .mst_ar_user(mst_ar_user), .mst_ar_valid(mst_ar_valid),
        .mst_ar_ready(mst_ar_ready),
        .mst_r_id(mst_r_id), .mst_r_data(mst_r_data),
        .mst_r_resp(mst_r_resp), .mst_r_last(mst_r_last),
        .mst_r_user(mst_r_user), .mst_r_valid(mst_r_valid),
        .mst_r_ready(mst_r_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] data;
        logic [3:0]  resp;
        logic        last;
    } rexp_t;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
    } arexp_t;

    rexp_t  exp_r[$];
    arexp_t exp_ar[$];
    arexp_t memq[$];
    int     retire_q[$];
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     credit = 1000;
    int     beat = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expectations are queued when the request is issued.
    task automatic send_ar(input logic [3:0] id, input logic [3:0] snoop,
                           input logic [1:0] bar, input logic [63:0] addr,
                           input logic [7:0] len, output int acc,
                           output int stalls);
        bit fwd, err, done;
        rexp_t e;
        fwd = !bar[0] && (snoop inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h7});
        err = !bar[0] && (snoop inside {4'h4, 4'h5, 4'h6, 4'hA});
        if (fwd) begin
            exp_ar.push_back('{id: id, addr: addr, len: len});
            for (int b = 0; b <= int'(len); b++) begin
                e.id = id;
                e.data = addr + 64'(b);
                e.resp = {2'b00, addr[1:0]};
                e.last = (b == int'(len));
                exp_r.push_back(e);
            end
        end else begin
            e.id = id;
            e.data = 64'h0;
            e.resp = err ? 4'b0010 : 4'b0000;
            e.last = 1'b1;
            exp_r.push_back(e);
        end
        slv_ar_id = id;
        slv_ar_addr = addr;
        slv_ar_len = len;
        slv_ar_snoop = snoop;
        slv_ar_bar = bar;
        slv_ar_valid = 1'b1;
        stalls = 0;
        acc = -1;
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (slv_ar_ready) begin
                done = 1;
                acc = cyc;
                if (fwd) chk("ar_same_cycle", 64'(mst_ar_valid), 64'd1);
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        slv_ar_valid = 1'b0;
        if (!done) chk("ar_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_r.size() != 0 || exp_ar.size() != 0) && k < 500) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk(name, 64'(exp_r.size() + exp_ar.size()), 64'd0);
    endtask

    // In-order AXI memory; credit limits how many beats it may return.
    initial begin
        arexp_t a;
        bit arh, rh, rl;
        mst_r_valid = 1'b0;
        mst_r_id = '0;
        mst_r_data = '0;
        mst_r_resp = '0;
        mst_r_last = 1'b0;
        mst_r_user = '0;
        forever begin
            @(negedge clk);
            arh = mst_ar_valid && mst_ar_ready;
            a.id = mst_ar_id;
            a.addr = mst_ar_addr;
            a.len = mst_ar_len;
            rh = mst_r_valid && mst_r_ready;
            rl = mst_r_last;
            if (rh && rl) retire_q.push_back(cyc);
            @(posedge clk);
            #2;
            if (rst_i) begin
                memq.delete();
                beat = 0;
                mst_r_valid = 1'b0;
            end else begin
                if (rh) begin
                    if (credit > 0) credit--;
                    if (rl) begin
                        void'(memq.pop_front());
                        beat = 0;
                    end else begin
                        beat++;
                    end
                end
                if (arh) memq.push_back(a);
                if (memq.size() != 0 && credit > 0) begin
                    mst_r_valid = 1'b1;
                    mst_r_id = memq[0].id;
                    mst_r_data = memq[0].addr + 64'(beat);
                    mst_r_resp = memq[0].addr[1:0];
                    mst_r_last = (beat == int'(memq[0].len));
                    mst_r_user = 1'b1;
                end else begin
                    mst_r_valid = 1'b0;
                end
            end
        end
    end

    // Downstream AR monitor: every forwarded AR must match in order.
    initial begin
        arexp_t a;
        forever begin
            @(negedge clk);
            if (!rst_i && mst_ar_valid && mst_ar_ready) begin
                if (exp_ar.size() == 0) begin
                    chk("mst_ar_unexpected", 64'd1, 64'd0);
                end else begin
                    a = exp_ar.pop_front();
                    chk("mst_ar_id", 64'(mst_ar_id), 64'(a.id));
                    chk("mst_ar_addr", mst_ar_addr, a.addr);
                    chk("mst_ar_len", 64'(mst_ar_len), 64'(a.len));
                end
            end
        end
    end

    // Upstream R monitor with stall-stability check.
    initial begin
        rexp_t e;
        bit stalled = 0;
        logic [9:0] pctl;
        logic [63:0] pdata;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    chk("r_hold_ctl",
                        64'({slv_r_valid, slv_r_id, slv_r_resp, slv_r_last}),
                        64'(pctl));
                    chk("r_hold_data", slv_r_data, pdata);
                end
                if (slv_r_valid && slv_r_ready) begin
                    if (exp_r.size() == 0) begin
                        chk("slv_r_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = exp_r.pop_front();
                        chk("slv_r_id", 64'(slv_r_id), 64'(e.id));
                        chk("slv_r_data", slv_r_data, e.data);
                        chk("slv_r_resp", 64'(slv_r_resp), 64'(e.resp));
                        chk("slv_r_last", 64'(slv_r_last), 64'(e.last));
                    end
                end
                stalled = slv_r_valid && !slv_r_ready;
                pctl = {1'b1, slv_r_id, slv_r_resp, slv_r_last};
                pdata = slv_r_data;
            end
        end
    end

    task automatic chk_quiet(input string name);
        chk({name, "_slv_ar_ready"}, 64'(slv_ar_ready), 64'd0);
        chk({name, "_slv_r_valid"}, 64'(slv_r_valid), 64'd0);
        chk({name, "_mst_ar_valid"}, 64'(mst_ar_valid), 64'd0);
        chk({name, "_mst_r_ready"}, 64'(mst_r_ready), 64'd0);
    endtask

    initial begin
        int acc, st, acc3, st3;
        rst_i = 1'b1;
        slv_ar_id = '0;
        slv_ar_addr = '0;
        slv_ar_len = '0;
        slv_ar_size = 3'd3;
        slv_ar_burst = 2'b01;
        slv_ar_lock = 1'b0;
        slv_ar_cache = 4'h2;
        slv_ar_prot = '0;
        slv_ar_qos = '0;
        slv_ar_region = '0;
        slv_ar_user = 1'b1;
        slv_ar_snoop = '0;
        slv_ar_bar = '0;
        slv_ar_domain = 2'b01;
        slv_ar_valid = 1'b1;
        slv_r_ready = 1'b1;
        mst_ar_ready = 1'b1;
        @(negedge clk);
        chk_quiet("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        slv_ar_valid = 1'b0;
        rst_i = 1'b0;
        chk("reset_cnt", 64'(dut.cnt_q), 64'd0);

        // 1: ReadShared, 4 beats
        send_ar(4'd3, 4'b0001, 2'b00, 64'h1000, 8'd3, acc, st);
        chk("t1_cnt_one", 64'(dut.cnt_q), 64'd1);
        drain("t1_drain");
        chk("t1_cnt_zero", 64'(dut.cnt_q), 64'd0);

        // widening of a non-zero AXI resp (EXOKAY)
        send_ar(4'd4, 4'b0111, 2'b00, 64'h2001, 8'd1, acc, st);
        drain("t1b_drain");

        // 2: outstanding limit of two
        credit = 0;
        retire_q.delete();
        send_ar(4'd6, 4'b0000, 2'b00, 64'h6000, 8'd0, acc, st);
        send_ar(4'd8, 4'b0000, 2'b00, 64'h6010, 8'd0, acc, st);
        fork
            send_ar(4'd9, 4'b0000, 2'b00, 64'h6020, 8'd0, acc3, st3);
            begin
                repeat (4) @(posedge clk);
                #1;
                credit = 1;
            end
        join
        chk("t2_stalled", 64'(st3 > 0), 64'd1);
        chk("t2_retired", 64'(retire_q.size()), 64'd1);
        if (retire_q.size() != 0)
            chk("t2_accept_after_retire", 64'(acc3), 64'(retire_q[0] + 1));
        credit = 1000;
        drain("t2_drain");

        // 3: barrier behind two outstanding reads
        credit = 0;
        send_ar(4'd1, 4'b0001, 2'b00, 64'h4000, 8'd1, acc, st);
        send_ar(4'd2, 4'b0001, 2'b00, 64'h5002, 8'd1, acc, st);
        send_ar(4'd5, 4'b0000, 2'b01, 64'h0, 8'd0, acc, st);
        chk("t3_bar_no_stall", 64'(st), 64'd0);
        repeat (3) @(negedge clk);
        chk("t3_no_r_while_draining", 64'(slv_r_valid), 64'd0);
        @(posedge clk);
        #1;
        credit = 1000;
        drain("t3_drain");

        // 4: CleanInvalid with upstream back-pressure
        slv_r_ready = 1'b0;
        send_ar(4'd7, 4'b1001, 2'b00, 64'h0, 8'd0, acc, st);
        @(negedge clk);
        chk("t4_r_next_cycle", 64'(slv_r_valid), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        slv_r_ready = 1'b1;
        drain("t4_drain");
        @(negedge clk);
        chk("t4_idle_no_r", 64'(slv_r_valid), 64'd0);
        @(posedge clk);
        #1;

        // 5: reserved encodings and DVM
        send_ar(4'd2, 4'b0101, 2'b00, 64'h0, 8'd0, acc, st);
        drain("t5_drain");
        send_ar(4'd10, 4'b1010, 2'b00, 64'h0, 8'd0, acc, st);
        send_ar(4'd11, 4'b1111, 2'b00, 64'h0, 8'd0, acc, st);
        drain("t5b_drain");

        // 6: reset while draining
        credit = 0;
        send_ar(4'd1, 4'b0000, 2'b00, 64'h3000, 8'd0, acc, st);
        send_ar(4'd4, 4'b1000, 2'b00, 64'h0, 8'd0, acc, st);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        slv_ar_valid = 1'b1;
        slv_ar_snoop = 4'b0000;
        @(negedge clk);
        chk_quiet("t6_in_reset");
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        slv_ar_valid = 1'b0;
        exp_r.delete();
        chk("t6_cnt", 64'(dut.cnt_q), 64'd0);
        chk("t6_state", 64'(dut.state_q), 64'd0);
        credit = 1000;
        send_ar(4'd12, 4'b0000, 2'b00, 64'h7000, 8'd2, acc, st);
        drain("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
